// File: rtl/reverb_pio_pkg.sv
// Shared constants for the reverb status input PIO: Avalon register map,
// edge-capture mode encodings and bus width.
package reverb_pio_pkg;

  localparam int AV_DW = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/reverb_pio_edge_sync.sv
// Two-flop input synchronizer with per-bit edge detection, held off by an
// arm counter until the synchronizer pipe has filled after reset.
module reverb_pio_edge_sync
  import reverb_pio_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_data,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [1:0]       arm_q;
  logic [1:0]       arm_d;
  logic [WIDTH-1:0] edge_raw_s;
  logic             armed_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      arm_q   <= 2'd0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      arm_q   <= arm_d;
    end
  end

  // Arming saturates at 3, once sync2 and prev both hold post-reset samples.
  always_comb begin
    arm_d      = arm_q;
    edge_raw_s = '0;
    if (arm_q == 2'd3) begin
      arm_d = arm_q;
    end else begin
      arm_d = arm_q + 2'd1;
    end
    armed_s = (arm_q == 2'd3);
    case (EDGE_TYPE)
      EDGE_RISING:  edge_raw_s = sync2_q & ~prev_q;
      EDGE_FALLING: edge_raw_s = ~sync2_q & prev_q;
      EDGE_ANY:     edge_raw_s = sync2_q ^ prev_q;
      default:      edge_raw_s = sync2_q & ~prev_q;
    endcase
  end

  assign sync_data  = sync2_q;
  assign edge_pulse = armed_s ? edge_raw_s : '0;

endmodule

// File: rtl/reverb_status_in_pio.sv
// Avalon-MM input PIO: synchronized status word, write-1-to-clear edge
// capture, interrupt mask and a registered level interrupt.
module reverb_status_in_pio
  import reverb_pio_pkg::*;
#(
  parameter int          WIDTH           = 24,
  parameter int          EDGE_TYPE       = EDGE_RISING,
  parameter logic [31:0] RESET_DATA_MASK = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_data_s;
  logic [WIDTH-1:0] edge_pulse_s;
  logic [WIDTH-1:0] edge_cap_q;
  logic [WIDTH-1:0] edge_cap_d;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] irq_mask_d;
  logic [AV_DW-1:0] readdata_q;
  logic [AV_DW-1:0] readdata_d;
  logic             irq_q;
  logic             irq_d;
  logic             wr_s;
  logic             unused_wdata_s;

  reverb_pio_edge_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge_sync (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .sync_data  (sync_data_s),
    .edge_pulse (edge_pulse_s)
  );

  assign wr_s           = chipselect & ~write_n;
  assign unused_wdata_s = ^writedata;

  always_comb begin
    edge_cap_d = edge_cap_q;
    irq_mask_d = irq_mask_q;
    readdata_d = '0;
    if (wr_s && (address == ADDR_EDGECAP)) begin
      edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
    end else begin
      edge_cap_d = edge_cap_q;
    end
    // A new edge overrides a same-cycle clear of that bit.
    edge_cap_d = edge_cap_d | edge_pulse_s;
    if (wr_s && (address == ADDR_IRQMASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end else begin
      irq_mask_d = irq_mask_q;
    end
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = sync_data_s;
      ADDR_RSVD:    readdata_d            = '0;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_cap_q;
      default:      readdata_d            = '0;
    endcase
    irq_d = |(edge_cap_q & irq_mask_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap_q <= '0;
      irq_mask_q <= RESET_DATA_MASK[WIDTH-1:0];
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      edge_cap_q <= edge_cap_d;
      irq_mask_q <= irq_mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_reverb_status_in_pio.sv
// Scoreboard bench for reverb_status_in_pio: a rising-edge instance and an
// any-edge instance share the Avalon bus; expected values are queued by the
// stimulus and consumed by an independent monitor.
module tb_reverb_status_in_pio;

  logic        clk = 1'b0;
  logic        rst0, rst2;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [23:0] in0, in2;
  logic [31:0] readdata0, readdata2;
  logic        irq0, irq2;

  typedef struct {
    bit          is_irq;
    bit          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic req_rd  = 1'b0;
  logic req_irq = 1'b0;
  logic req_sel = 1'b0;
  logic rd_vld_q = 1'b0;
  logic rd_sel_q = 1'b0;

  always #5 clk = ~clk;

  reverb_status_in_pio #(.WIDTH(24), .EDGE_TYPE(0), .RESET_DATA_MASK(32'h0)) dut0 (
    .clk(clk), .reset(rst0), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(readdata0), .irq(irq0)
  );

  reverb_status_in_pio #(.WIDTH(24), .EDGE_TYPE(2), .RESET_DATA_MASK(32'h0)) dut2 (
    .clk(clk), .reset(rst2), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2),
    .readdata(readdata2), .irq(irq2)
  );

  task automatic check(input bit is_irq, input logic [31:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sb_underflow: output observed with no expected entry (actual 0x%08h)", act);
    end else begin
      e = sb_q.pop_front();
      n_cmp++;
      if (e.is_irq != is_irq || act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: actual 0x%08h required 0x%08h", e.name, act, e.exp);
      end
    end
  endtask

  // Monitor: read data is one cycle after the request; irq is sampled in-cycle.
  always @(posedge clk) begin
    rd_vld_q <= req_rd;
    rd_sel_q <= req_sel;
  end

  always @(negedge clk) begin
    if (rd_vld_q) check(1'b0, rd_sel_q ? readdata2 : readdata0);
    if (req_irq)  check(1'b1, {31'd0, (req_sel ? irq2 : irq0)});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input bit sel, input logic [1:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.is_irq = 1'b0; e.sel = sel; e.exp = exp; e.name = name;
    sb_q.push_back(e);
    address = a;
    req_sel = sel;
    req_rd  = 1'b1;
    tick();
    req_rd  = 1'b0;
  endtask

  task automatic irqchk(input bit sel, input logic exp, input string name);
    exp_t e;
    e.is_irq = 1'b1; e.sel = sel; e.exp = {31'd0, exp}; e.name = name;
    sb_q.push_back(e);
    req_sel = sel;
    req_irq = 1'b1;
    tick();
    req_irq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; rst2 = 1'b1;
    address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    in0 = 24'hFFFFFF; in2 = 24'h000000;
    repeat (3) tick();
    rst0 = 1'b0; rst2 = 1'b0;
    repeat (10) tick();

    // Static-high input through reset: visible as data, never captured.
    rd(1'b0, 2'd0, 32'h00FFFFFF, "t1_data");
    rd(1'b0, 2'd3, 32'h0, "t1_ecap");
    rd(1'b0, 2'd2, 32'h0, "t1_mask");
    irqchk(1'b0, 1'b0, "t1_irq");

    // Falling edges are ignored in rising mode; then a rising edge on bit 0.
    in0 = 24'h000000;
    repeat (4) tick();
    rd(1'b0, 2'd3, 32'h0, "t2_no_fall");
    wr(2'd2, 32'h1);
    in0 = 24'h000001;
    tick();
    rd(1'b0, 2'd0, 32'h0, "t2_data_early");
    rd(1'b0, 2'd0, 32'h1, "t2_data");
    irqchk(1'b0, 1'b0, "t2_irq_pre");
    irqchk(1'b0, 1'b1, "t2_irq_rise");
    rd(1'b0, 2'd3, 32'h1, "t2_ecap");

    // Clear coinciding with a fresh edge: edge wins. Then a plain clear.
    in0 = 24'h000000;
    repeat (4) tick();
    in0 = 24'h000001;
    tick();
    tick();
    wr(2'd3, 32'h1);
    rd(1'b0, 2'd3, 32'h1, "t3_edge_wins");
    irqchk(1'b0, 1'b1, "t3_irq_held");
    wr(2'd3, 32'h1);
    irqchk(1'b0, 1'b1, "t3_irq_lag");
    irqchk(1'b0, 1'b0, "t3_irq_fall");
    rd(1'b0, 2'd3, 32'h0, "t3_cleared");

    // Mask gating of pending captures.
    in0 = 24'h000000;
    repeat (4) tick();
    in0 = 24'h0000A5;
    repeat (4) tick();
    rd(1'b0, 2'd3, 32'h000000A5, "t4_ecap");
    irqchk(1'b0, 1'b1, "t4_irq_pending");
    wr(2'd2, 32'h0);
    irqchk(1'b0, 1'b1, "t4_irq_lag");
    irqchk(1'b0, 1'b0, "t4_irq_masked");
    rd(1'b0, 2'd3, 32'h000000A5, "t4_ecap_kept");
    wr(2'd2, 32'h80);
    irqchk(1'b0, 1'b0, "t4_irq_lag2");
    irqchk(1'b0, 1'b1, "t4_irq_unmask");

    // Read-only data, reserved word, and zeroed upper bits.
    wr(2'd0, 32'h5A);
    wr(2'd1, 32'h5A);
    rd(1'b0, 2'd0, 32'h000000A5, "t5_data");
    rd(1'b0, 2'd1, 32'h0, "t5_rsvd");
    wr(2'd2, 32'hFFFFFFFF);
    rd(1'b0, 2'd2, 32'h00FFFFFF, "t5_mask_hi");
    in0 = 24'hFFFFFF;
    repeat (4) tick();
    rd(1'b0, 2'd0, 32'h00FFFFFF, "t5_data_hi");
    rd(1'b0, 2'd3, 32'h00FFFFFF, "t5_ecap_hi");

    // Any-edge instance: a 3-clk pulse on bit 23.
    in2 = 24'h800000;
    repeat (3) tick();
    in2 = 24'h000000;
    repeat (5) tick();
    rd(1'b1, 2'd3, 32'h00800000, "t6_any_ecap");
    irqchk(1'b1, 1'b1, "t6_irq");
    wr(2'd3, 32'h00FFFFFF);
    tick();
    rd(1'b1, 2'd3, 32'h0, "t6_clr");

    // Reset in the middle of a pulse, input still high on release.
    in2 = 24'h800000;
    tick();
    tick();
    rst2 = 1'b1;
    rd(1'b1, 2'd0, 32'h0, "t6_rst_data");
    rd(1'b1, 2'd3, 32'h0, "t6_rst_ecap");
    irqchk(1'b1, 1'b0, "t6_rst_irq");
    rst2 = 1'b0;
    repeat (3) tick();
    rd(1'b1, 2'd3, 32'h0, "t6_arm_quiet");
    repeat (4) tick();
    rd(1'b1, 2'd3, 32'h0, "t6_static_high");
    rd(1'b1, 2'd0, 32'h00800000, "t6_data");
    rd(1'b1, 2'd2, 32'h0, "t6_mask_reset");
    in2 = 24'h000000;
    repeat (4) tick();
    rd(1'b1, 2'd3, 32'h00800000, "t6_fall_any");

    tick();
    tick();
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sb_drain: actual %0d entries left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
